fp_alu_arbiter: RTL and testbench

Two-requester, round-robin arbiter and sequencer for the shared single-precision FP ALU (add when `selector`=0, multiply when `selector`=1). It accepts operations over valid/ready handshakes, registers the operands onto the ALU, and holds them for a configurable settle time. It then captures `Result`/`carry`/`overflow` into a registered response tagged with the requester ID. The block sits between the two FP-issuing clients and the single combinational ALU instance.

---
 rtl/fp_alu_arb_if.sv | 57 +++++
 rtl/fp_alu_arbiter.sv | 141 ++++++++++++++
 tb/tb_fp_alu_arbiter.sv | 388 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_alu_arb_if.sv
// Bundle between the two FP clients, the shared combinational FP ALU and the
// response consumer. The slave modport is the arbiter side.
interface fp_alu_arb_if;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned OVF_W  = 8;

    logic              req0_valid;
    logic              req0_ready;
    logic [DATA_W-1:0] req0_a;
    logic [DATA_W-1:0] req0_b;
    logic              req0_sel;

    logic              req1_valid;
    logic              req1_ready;
    logic [DATA_W-1:0] req1_a;
    logic [DATA_W-1:0] req1_b;
    logic              req1_sel;

    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic              alu_selector;
    logic [DATA_W-1:0] alu_result;
    logic              alu_carry;
    logic              alu_overflow;

    logic              resp_valid;
    logic              resp_ready;
    logic              resp_id;
    logic [DATA_W-1:0] resp_result;
    logic              resp_carry;
    logic              resp_overflow;

    logic [OVF_W-1:0]  ovf_count;
    logic              busy;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_sel,
        input  req1_valid, req1_a, req1_b, req1_sel,
        input  alu_result, alu_carry, alu_overflow,
        input  resp_ready,
        output req0_ready, req1_ready,
        output alu_a, alu_b, alu_selector,
        output resp_valid, resp_id, resp_result, resp_carry, resp_overflow,
        output ovf_count, busy
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_sel,
        output req1_valid, req1_a, req1_b, req1_sel,
        output alu_result, alu_carry, alu_overflow,
        output resp_ready,
        input  req0_ready, req1_ready,
        input  alu_a, alu_b, alu_selector,
        input  resp_valid, resp_id, resp_result, resp_carry, resp_overflow,
        input  ovf_count, busy
    );
endinterface

// File: rtl/fp_alu_arbiter.sv
// Round-robin arbiter and sequencer for one shared FP add/mul ALU: registers the
// granted operands, waits ALU_LAT cycles, then presents a tagged response.
module fp_alu_arbiter #(
    parameter int unsigned ALU_LAT = 1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    fp_alu_arb_if.slave  bus
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned OVF_W  = 8;
    localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(ALU_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_last_grant;
    logic               r_id;
    logic [CNT_W-1:0]   r_cnt;
    logic [DATA_W-1:0]  r_alu_a;
    logic [DATA_W-1:0]  r_alu_b;
    logic               r_alu_sel;
    logic               r_resp_valid;
    logic               r_resp_id;
    logic [DATA_W-1:0]  r_resp_result;
    logic               r_resp_carry;
    logic               r_resp_overflow;
    logic [OVF_W-1:0]   r_ovf_count;
    logic               r_busy;

    logic               w_any;
    logic               w_grant;
    logic               w_accept;
    logic               w_capture;
    logic               w_resp_done;

    // A lone valid wins; a tie goes to the requester not served last
    always_comb begin
        w_any   = bus.req0_valid | bus.req1_valid;
        w_grant = (bus.req0_valid && bus.req1_valid) ? ~r_last_grant : bus.req1_valid;
    end

    assign bus.req0_ready = (r_state == S_IDLE) && bus.req0_valid && !w_grant;
    assign bus.req1_ready = (r_state == S_IDLE) && bus.req1_valid &&  w_grant;

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        w_resp_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                if (r_cnt == LAT_LAST) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.resp_ready) begin
                    w_resp_done = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Operand, settle-counter and response registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last_grant    <= 1'b1;
            r_id            <= 1'b0;
            r_cnt           <= '0;
            r_alu_a         <= '0;
            r_alu_b         <= '0;
            r_alu_sel       <= 1'b0;
            r_resp_valid    <= 1'b0;
            r_resp_id       <= 1'b0;
            r_resp_result   <= '0;
            r_resp_carry    <= 1'b0;
            r_resp_overflow <= 1'b0;
            r_ovf_count     <= '0;
            r_busy          <= 1'b0;
        end else begin
            if (w_accept) begin
                r_alu_a      <= w_grant ? bus.req1_a   : bus.req0_a;
                r_alu_b      <= w_grant ? bus.req1_b   : bus.req0_b;
                r_alu_sel    <= w_grant ? bus.req1_sel : bus.req0_sel;
                r_id         <= w_grant;
                r_last_grant <= w_grant;
                r_cnt        <= '0;
            end else if ((r_state == S_EXEC) && !w_capture) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            if (w_capture) begin
                r_resp_valid    <= 1'b1;
                r_resp_id       <= r_id;
                r_resp_result   <= bus.alu_result;
                r_resp_carry    <= bus.alu_carry;
                r_resp_overflow <= bus.alu_overflow;
            end

            if (w_resp_done) begin
                r_resp_valid <= 1'b0;
                if (r_resp_overflow && (r_ovf_count != '1))
                    r_ovf_count <= r_ovf_count + OVF_W'(1);
            end

            r_busy <= (w_state_nxt != S_IDLE);
        end
    end

    assign bus.alu_a         = r_alu_a;
    assign bus.alu_b         = r_alu_b;
    assign bus.alu_selector  = r_alu_sel;
    assign bus.resp_valid    = r_resp_valid;
    assign bus.resp_id       = r_resp_id;
    assign bus.resp_result   = r_resp_result;
    assign bus.resp_carry    = r_resp_carry;
    assign bus.resp_overflow = r_resp_overflow;
    assign bus.ovf_count     = r_ovf_count;
    assign bus.busy          = r_busy;
endmodule

// File: tb/tb_fp_alu_arbiter.sv
// Self-checking bench for fp_alu_arbiter: vector table, directed corner sequences,
// and randomized traffic against a transaction-level reference model.
module tb_fp_alu_arbiter;
    localparam int unsigned LAT_A = 1;
    localparam int unsigned LAT_B = 3;

    logic clk = 1'b0;
    logic rst;
    logic rst3;
    always #5 clk = ~clk;

    fp_alu_arb_if bus ();
    fp_alu_arb_if bus3 ();

    fp_alu_arbiter #(.ALU_LAT(LAT_A)) u_dut  (.i_clk(clk), .i_rst(rst),  .bus(bus.slave));
    fp_alu_arbiter #(.ALU_LAT(LAT_B)) u_dut3 (.i_clk(clk), .i_rst(rst3), .bus(bus3.slave));

    // Truncating single<->double conversions; zero/denormal inputs read as zero
    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        logic [10:0] e;
        if (f[30:23] == 8'd0) begin
            d = {f[31], 63'd0};
        end else begin
            e = (f[30:23] == 8'hFF) ? 11'h7FF : (11'(f[30:23]) + 11'd896);
            d = {f[31], e, f[22:0], 29'd0};
        end
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        int          e;
        d = $realtobits(r);
        e = int'(d[62:52]) - 896;
        if (d[62:52] == 11'h7FF) return {d[63], 8'hFF, d[51:29]};
        if (e >= 255)            return {d[63], 8'hFF, 23'd0};
        if (e <= 0)              return {d[63], 31'd0};
        return {d[63], 8'(e), d[51:29]};
    endfunction

    function automatic logic [31:0] fp_op(input logic [31:0] a, input logic [31:0] b, input logic sel);
        return sel ? r2f(f2r(a) * f2r(b)) : r2f(f2r(a) + f2r(b));
    endfunction

    // Stand-in ALUs: carry reports the result sign, overflow an all-ones exponent
    assign bus.alu_result    = fp_op(bus.alu_a, bus.alu_b, bus.alu_selector);
    assign bus.alu_carry     = bus.alu_result[31];
    assign bus.alu_overflow  = &bus.alu_result[30:23];
    assign bus3.alu_result   = fp_op(bus3.alu_a, bus3.alu_b, bus3.alu_selector);
    assign bus3.alu_carry    = bus3.alu_result[31];
    assign bus3.alu_overflow = &bus3.alu_result[30:23];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_sel = 1'b0;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_sel = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic wait_resp(output int lat);
        lat = 1;
        while (!bus.resp_valid && lat < 20) begin
            step();
            lat++;
        end
        check1("resp_wait", bus.resp_valid, 1'b1);
    endtask

    typedef struct {
        logic        v0;
        logic        v1;
        logic [31:0] a0;
        logic [31:0] b0;
        logic        s0;
        logic [31:0] a1;
        logic [31:0] b1;
        logic        s1;
        logic        exp_id;
        logic [31:0] exp_res;
        logic        exp_c;
        logic        exp_o;
    } vec_t;

    typedef struct {
        logic        id;
        logic [31:0] res;
        logic        c;
        logic        o;
    } rsp_t;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs [6];
        int          lat;
        logic        exp_g;
        int          grants;
        logic        gq [$];
        rsp_t        mq [$];
        logic [31:0] pool [8];

        vecs[0] = '{1'b1, 1'b0, 32'h3F800000, 32'h40000000, 1'b0, 32'h0, 32'h0, 1'b0,
                    1'b0, 32'h40400000, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 32'h3F800000, 32'h40000000, 1'b0, 32'h3F800000, 32'hBF800000, 1'b1,
                    1'b1, 32'hBF800000, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 32'h3F800000, 32'h40000000, 1'b0, 32'h3F800000, 32'hBF800000, 1'b1,
                    1'b0, 32'h40400000, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 32'h40000000, 32'h40000000, 1'b0,
                    1'b1, 32'h40800000, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 32'h7F800000, 32'h7F800000, 1'b1, 32'h3F800000, 32'hBF800000, 1'b1,
                    1'b0, 32'h7F800000, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 32'h4F000000, 32'h4E800000, 1'b1,
                    1'b1, 32'h5E000000, 1'b0, 1'b0};

        pool = '{32'h3F800000, 32'h40000000, 32'hBF800000, 32'h7F800000,
                 32'h7F000000, 32'h00000000, 32'h4F000000, 32'hC1200000};

        clear_reqs();
        bus.resp_ready = 1'b1;
        bus3.req0_valid = 1'b0; bus3.req0_a = '0; bus3.req0_b = '0; bus3.req0_sel = 1'b0;
        bus3.req1_valid = 1'b0; bus3.req1_a = '0; bus3.req1_b = '0; bus3.req1_sel = 1'b0;
        bus3.resp_ready = 1'b1;
        rst = 1'b1;
        rst3 = 1'b1;
        step();
        step();
        rst = 1'b0;
        rst3 = 1'b0;

        // Reset values
        check("rst_alu_a", bus.alu_a, 32'h0);
        check("rst_alu_b", bus.alu_b, 32'h0);
        check1("rst_alu_sel", bus.alu_selector, 1'b0);
        check1("rst_resp_valid", bus.resp_valid, 1'b0);
        check1("rst_resp_id", bus.resp_id, 1'b0);
        check("rst_resp_result", bus.resp_result, 32'h0);
        check1("rst_resp_carry", bus.resp_carry, 1'b0);
        check1("rst_resp_ovf", bus.resp_overflow, 1'b0);
        check("rst_ovf_count", 32'(bus.ovf_count), 32'h0);
        check1("rst_busy", bus.busy, 1'b0);
        check1("rst_ready0", bus.req0_ready, 1'b0);
        check1("rst_ready1", bus.req1_ready, 1'b0);

        // Vector table: one operation at a time with resp_ready held high
        foreach (vecs[i]) begin
            bus.req0_valid = vecs[i].v0; bus.req0_a = vecs[i].a0; bus.req0_b = vecs[i].b0; bus.req0_sel = vecs[i].s0;
            bus.req1_valid = vecs[i].v1; bus.req1_a = vecs[i].a1; bus.req1_b = vecs[i].b1; bus.req1_sel = vecs[i].s1;
            #1;
            check1("vec_ready0", bus.req0_ready, vecs[i].exp_id == 1'b0);
            check1("vec_ready1", bus.req1_ready, vecs[i].exp_id == 1'b1);
            step();
            clear_reqs();
            wait_resp(lat);
            check("vec_latency", 32'(lat), 32'(LAT_A + 1));
            check1("vec_id", bus.resp_id, vecs[i].exp_id);
            check("vec_result", bus.resp_result, vecs[i].exp_res);
            check1("vec_carry", bus.resp_carry, vecs[i].exp_c);
            check1("vec_ovf", bus.resp_overflow, vecs[i].exp_o);
            step();
            check1("vec_busy_after", bus.busy, 1'b0);
            check1("vec_valid_after", bus.resp_valid, 1'b0);
        end
        check("vec_ovf_count", 32'(bus.ovf_count), 32'd1);

        // Backpressure: response held for 10 cycles, both requesters stalled
        bus.resp_ready = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_a = 32'h3F800000; bus.req0_b = 32'h40000000; bus.req0_sel = 1'b0;
        bus.req1_valid = 1'b1; bus.req1_a = 32'h3F800000; bus.req1_b = 32'hBF800000; bus.req1_sel = 1'b1;
        #1;
        check1("bp_grant0", bus.req0_ready, 1'b1);
        step();
        check1("bp_exec_ready0", bus.req0_ready, 1'b0);
        check1("bp_exec_ready1", bus.req1_ready, 1'b0);
        wait_resp(lat);
        for (int c = 0; c < 10; c++) begin
            check1("bp_valid", bus.resp_valid, 1'b1);
            check1("bp_id", bus.resp_id, 1'b0);
            check("bp_result", bus.resp_result, 32'h40400000);
            check1("bp_ready0", bus.req0_ready, 1'b0);
            check1("bp_ready1", bus.req1_ready, 1'b0);
            check1("bp_busy", bus.busy, 1'b1);
            step();
        end
        bus.resp_ready = 1'b1;
        check1("bp_valid_last", bus.resp_valid, 1'b1);
        step();
        check1("bp_released", bus.resp_valid, 1'b0);
        check1("bp_next_ready1", bus.req1_ready, 1'b1);
        check1("bp_next_ready0", bus.req0_ready, 1'b0);
        clear_reqs();

        // Contention after reset: strict 0,1,0,1 alternation
        do_reset();
        bus.req0_valid = 1'b1; bus.req0_a = 32'h3F800000; bus.req0_b = 32'h40000000; bus.req0_sel = 1'b0;
        bus.req1_valid = 1'b1; bus.req1_a = 32'h3F800000; bus.req1_b = 32'hBF800000; bus.req1_sel = 1'b1;
        #1;
        exp_g = 1'b0;
        grants = 0;
        for (int c = 0; c < 16; c++) begin
            check1("ct_exclusive", bus.req0_ready && bus.req1_ready, 1'b0);
            if (bus.resp_valid) begin
                check1("ct_resp_id", bus.resp_id, (gq.size() > 0) ? gq[0] : 1'bx);
                check("ct_resp_result", bus.resp_result, bus.resp_id ? 32'hBF800000 : 32'h40400000);
                if (gq.size() > 0) void'(gq.pop_front());
            end
            if (bus.req0_ready || bus.req1_ready) begin
                check1("ct_grant", bus.req1_ready, exp_g);
                gq.push_back(exp_g);
                exp_g = ~exp_g;
                grants++;
            end
            step();
        end
        check("ct_grant_count", 32'(grants), 32'd6);
        clear_reqs();
        step();
        step();

        // Overflow counter saturates at 255
        do_reset();
        for (int k = 0; k < 300; k++) begin
            bus.req0_valid = 1'b1; bus.req0_a = 32'h7F800000; bus.req0_b = 32'h7F800000; bus.req0_sel = 1'b1;
            #1;
            step();
            clear_reqs();
            wait_resp(lat);
            check1("ovf_flag", bus.resp_overflow, 1'b1);
            step();
            check("ovf_count", 32'(bus.ovf_count), (k + 1 > 255) ? 32'd255 : 32'(k + 1));
        end

        // Reset during EXEC, then during RESP
        bus.req0_valid = 1'b1; bus.req0_a = 32'h7F800000; bus.req0_b = 32'h7F800000; bus.req0_sel = 1'b1;
        #1;
        step();
        clear_reqs();
        check1("rx_in_exec", bus.busy, 1'b1);
        do_reset();
        check1("rx_exec_valid", bus.resp_valid, 1'b0);
        check1("rx_exec_busy", bus.busy, 1'b0);
        check("rx_exec_ovf", 32'(bus.ovf_count), 32'd0);
        check("rx_exec_alu_a", bus.alu_a, 32'h0);
        for (int c = 0; c < 4; c++) begin
            check1("rx_no_stale", bus.resp_valid, 1'b0);
            step();
        end
        bus.resp_ready = 1'b0;
        bus.req1_valid = 1'b1; bus.req1_a = 32'h7F800000; bus.req1_b = 32'h7F800000; bus.req1_sel = 1'b1;
        #1;
        step();
        clear_reqs();
        wait_resp(lat);
        do_reset();
        bus.resp_ready = 1'b1;
        check1("rx_resp_valid", bus.resp_valid, 1'b0);
        check1("rx_resp_busy", bus.busy, 1'b0);
        check("rx_resp_result", bus.resp_result, 32'h0);
        check("rx_resp_ovf", 32'(bus.ovf_count), 32'd0);
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        #1;
        check1("rx_tie_ready0", bus.req0_ready, 1'b1);
        check1("rx_tie_ready1", bus.req1_ready, 1'b0);
        clear_reqs();
        #1;

        // Randomized traffic against a transaction-level model
        begin
            int   exec_left;
            logic m_last;
            int   m_ovf;
            logic m_idle;
            logic g;
            logic [31:0] op_a, op_b;
            logic        op_s, op_id;
            exec_left = 0; m_last = 1'b1; m_ovf = 0;
            op_a = '0; op_b = '0; op_s = 1'b0; op_id = 1'b0;
            mq.delete();
            do_reset();
            for (int c = 0; c < 1500; c++) begin
                bus.req0_valid = 1'($urandom_range(0, 1));
                bus.req1_valid = 1'($urandom_range(0, 1));
                bus.req0_a = ($urandom_range(0, 3) == 0) ? $urandom : pool[$urandom_range(0, 7)];
                bus.req0_b = pool[$urandom_range(0, 7)];
                bus.req0_sel = 1'($urandom_range(0, 1));
                bus.req1_a = pool[$urandom_range(0, 7)];
                bus.req1_b = ($urandom_range(0, 3) == 0) ? $urandom : pool[$urandom_range(0, 7)];
                bus.req1_sel = 1'($urandom_range(0, 1));
                bus.resp_ready = ($urandom_range(0, 3) != 0);
                #1;
                m_idle = (exec_left == 0) && (mq.size() == 0);
                g = (bus.req0_valid && bus.req1_valid) ? ~m_last : bus.req1_valid;
                check1("rnd_ready0", bus.req0_ready, m_idle && bus.req0_valid && !g);
                check1("rnd_ready1", bus.req1_ready, m_idle && bus.req1_valid && g);
                check1("rnd_busy", bus.busy, !m_idle);
                check1("rnd_resp_valid", bus.resp_valid, mq.size() > 0);
                check("rnd_ovf_count", 32'(bus.ovf_count), 32'(m_ovf));
                if (mq.size() > 0) begin
                    check1("rnd_resp_id", bus.resp_id, mq[0].id);
                    check("rnd_resp_result", bus.resp_result, mq[0].res);
                    check1("rnd_resp_carry", bus.resp_carry, mq[0].c);
                    check1("rnd_resp_ovf", bus.resp_overflow, mq[0].o);
                end
                if (exec_left > 0) begin
                    check("rnd_alu_a", bus.alu_a, op_a);
                    check("rnd_alu_b", bus.alu_b, op_b);
                    check1("rnd_alu_sel", bus.alu_selector, op_s);
                end
                if (m_idle && (bus.req0_valid || bus.req1_valid)) begin
                    op_a = g ? bus.req1_a : bus.req0_a;
                    op_b = g ? bus.req1_b : bus.req0_b;
                    op_s = g ? bus.req1_sel : bus.req0_sel;
                    op_id = g;
                    m_last = g;
                    exec_left = LAT_A;
                end else if (exec_left > 0) begin
                    exec_left--;
                    if (exec_left == 0) begin
                        logic [31:0] r;
                        r = fp_op(op_a, op_b, op_s);
                        mq.push_back('{op_id, r, r[31], &r[30:23]});
                    end
                end else if ((mq.size() > 0) && bus.resp_ready) begin
                    if (mq[0].o && m_ovf < 255) m_ovf++;
                    void'(mq.pop_front());
                end
                step();
            end
            clear_reqs();
            bus.resp_ready = 1'b1;
        end

        // ALU_LAT=3 instance: operands held 3 cycles, response 4 cycles after accept
        bus3.req1_valid = 1'b1; bus3.req1_a = 32'h4F000000; bus3.req1_b = 32'h4E800000; bus3.req1_sel = 1'b1;
        #1;
        check1("l3_ready1", bus3.req1_ready, 1'b1);
        step();
        bus3.req1_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            check("l3_alu_a", bus3.alu_a, 32'h4F000000);
            check("l3_alu_b", bus3.alu_b, 32'h4E800000);
            check1("l3_alu_sel", bus3.alu_selector, 1'b1);
            check1("l3_not_yet", bus3.resp_valid, 1'b0);
            step();
        end
        check1("l3_resp_valid", bus3.resp_valid, 1'b1);
        check1("l3_resp_id", bus3.resp_id, 1'b1);
        check("l3_resp_result", bus3.resp_result, 32'h5E000000);
        step();
        check1("l3_resp_done", bus3.resp_valid, 1'b0);
        check1("l3_busy", bus3.busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
